// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of mem_port_arbiter.
// slave  : the arbiter's view (takes requests and mem_rdata, drives acks and the memory bus).
// master : the environment's view (both requesters plus the memory system).
interface mem_port_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [DATA_W-1:0] mem_data;
    logic              mem_store;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output mem_data, mem_store, mem_addr, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  mem_data, mem_store, mem_addr, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the 4 x 8-bit
// store-gated memory. One access takes IDLE -> ACCESS -> DONE.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting; arbitrates and latches the winner's request
//   ACCESS | drives addr/data, store strobe high for writes
//   DONE   | holds addr/data for latch hold time, acks the winner
module mem_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic              grant_b_q, grant_b_d;   // winner of the current access: 0 = A, 1 = B
    logic              ptr_b_q,   ptr_b_d;     // priority on a tie: 0 = A, 1 = B
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              sel_b;

    // Next-state logic: arbitration and request capture in IDLE, read capture on ACCESS -> DONE.
    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        ptr_b_d   = ptr_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        sel_b     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    sel_b     = bus.b_req && (!bus.a_req || ptr_b_q);
                    grant_b_d = sel_b;
                    we_d      = sel_b ? bus.b_we    : bus.a_we;
                    addr_d    = sel_b ? bus.b_addr  : bus.a_addr;
                    wdata_d   = sel_b ? bus.b_wdata : bus.a_wdata;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // The memory read path is transparent while storing, so a write
                // returns the written word here.
                if (grant_b_q) begin
                    b_rdata_d = bus.mem_rdata;
                end else begin
                    a_rdata_d = bus.mem_rdata;
                end
                state_d = DONE;
            end
            DONE: begin
                ptr_b_d = !grant_b_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_b_q <= 1'b0;
            ptr_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            ptr_b_q   <= ptr_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobes are gated by reset so an access interrupted mid-flight neither
    // stores nor acks during the reset cycle. The memory bus is parked at zero in IDLE.
    assign bus.mem_store = !reset && (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = (state_q != IDLE) ? addr_q  : '0;
    assign bus.mem_data  = (state_q != IDLE) ? wdata_q : '0;
    assign bus.a_ack     = !reset && (state_q == DONE) && !grant_b_q;
    assign bus.b_ack     = !reset && (state_q == DONE) &&  grant_b_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 4 x 8-bit store-gated memory system. It serialises read and write requests from ports A and B onto the single data/store/addr interface of the memory system. It drives a one-cycle store strobe for writes and returns read data with a one-cycle acknowledge. It sits between the two requesting masters and the memory system instance.

Parameters:
DATA_W, 8, width of data words.
ADDR_W, 2, width of the word address; the memory holds 2^ADDR_W words.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
a_req  input  1  port A request; held high until a_ack.
a_we  input  1  port A write enable (1 = write, 0 = read).
a_addr  input  ADDR_W  port A word address.
a_wdata  input  DATA_W  port A write data.
a_ack  output  1  one-cycle completion pulse to port A.
a_rdata  output  DATA_W  port A read data; valid while a_ack is high.
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as the A ports, for port B.
mem_data  output  DATA_W  data to the memory system.
mem_store  output  1  store strobe to the memory system.
mem_addr  output  ADDR_W  address to the memory system.
mem_rdata  input  DATA_W  selected word from the memory system (combinational).
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, synchronous and active-high: state = IDLE; priority pointer = A; all outputs = 0. This includes mem_store, both acks, both rdata and mem_addr/mem_data.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner's we, addr and wdata into internal registers, record the winner, and go to ACCESS.
  - Arbitration: if only one port requests, that port wins. If both request, the port named by the priority pointer wins.
- ACCESS, one cycle:
  - mem_addr and mem_data are driven from the latched registers.
  - mem_store = latched we.
  - Next state is DONE.
- DONE, one cycle:
  - mem_store = 0.
  - mem_addr and mem_data are held, giving hold time for the latch-based storage.
  - The winner's ack = 1.
  - The winner's rdata holds the value of mem_rdata captured on the ACCESS->DONE edge. For a write, this equals the written data.
  - The priority pointer is set to the non-winning port.
  - Next state is IDLE.
- Latency from a req sampled high in IDLE:
  - ACCESS is the next cycle.
  - ack is high 2 cycles after the sampling edge.
  - The earliest next grant is in the IDLE cycle after DONE, so maximum throughput is one access per 3 cycles.
- Ack is exactly one cycle. The non-winner's ack stays 0. rdata of the non-winner is unchanged.
- Requester inputs are sampled only in IDLE. Changes in a_addr/a_wdata/a_we during ACCESS or DONE have no effect.
- A requester must drop req in the cycle after ack. If req is still high in the IDLE following DONE, it is treated as a new request.
- Starvation-free: with both ports requesting continuously, grants alternate A, B, A, B, ...
- mem_store is never high outside ACCESS and is never high for reads.
- busy = 1 in ACCESS and DONE.
- Reset asserted mid-operation (ACCESS or DONE):
  - Return to IDLE next edge.
  - mem_store = 0 and no ack is issued.
  - The pointer returns to A.
  - An interrupted write may or may not have been stored.
- Address wrap: addresses are used unmodified, with no range check, since all 2^ADDR_W values are valid.

Test Plan:
1. Reset, then A writes 0xA5 to addr 2 -> mem_store high for exactly 1 cycle, with mem_addr=2 and mem_data=0xA5; a_ack high 2 cycles after request; b_ack stays 0.
2. After test 1, B reads addr 2 -> no mem_store; b_ack pulse with b_rdata=0xA5; a_rdata unchanged.
3. A and B both request writes in the same cycle after reset (A: addr0=0x11, B: addr1=0x22) -> A served first, B served 3 cycles later; reads then return 0x11 and 0x22.
4. Both ports hold req continuously for 6 transactions -> ack order A, B, A, B, A, B; mem_store never high in IDLE or DONE.
5. Write 0xFF to addr 3, then assert reset during ACCESS -> next cycle state IDLE, busy=0, mem_store=0, no ack; following simultaneous requests grant A first.
6. A write to each of addr 0-3 with values 0x01, 0x02, 0x04, 0x08, then reads of each -> the values read back match the values written, with no aliasing.
